// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state encoding, byte width and watchdog constants for the I2C transaction arbiter
package i2c_arb_pkg;
  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP, COMPLETE, FAIL} state_t;
  localparam int BYTE_W = 8;
  localparam int WDOG_W = 16;
  localparam logic [WDOG_W-1:0] WDOG_MAX = 16'hFFFF;
endpackage

// File: rtl/i2c_txn_arbiter_rr_select.sv
// rr_select: combinational round-robin pick of the first requester at or after ptr
module rr_select #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  // scanned farthest-first so the nearest requester is the last one written
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
      end
  end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C byte master with NACK retry.
// Define I2C_ARB_TIMEOUT_EN to add a 16-bit watchdog on the master handshake.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        grant_done,
  output logic [NUM_REQ-1:0]        grant_err,
  output logic                      m_start_tx,
  output logic [BYTE_W-1:0]         m_data_in,
  input  logic                      m_busy,
  input  logic                      m_done,
  input  logic                      m_nack,
  output logic                      arb_busy
);
  localparam int PW = $clog2(NUM_REQ);
  state_t state;
  logic [PW-1:0] rr_ptr, owner, sel_idx;
  logic [NUM_REQ-1:0] sel_gnt;
  logic [2:0] retry_cnt;
  logic [7:0] gap_cnt;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;
`endif
  rr_select #(.N(NUM_REQ)) u_sel (.req(req), .ptr(rr_ptr), .gnt(sel_gnt), .idx(sel_idx));
  assign arb_busy = state != IDLE;
  // pulse outputs are set on the transition into their state so they are high during it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_done <= '0;
      grant_err <= '0;
      m_start_tx <= 1'b0;
      m_data_in <= '0;
      retry_cnt <= '0;
      gap_cnt <= '0;
      rr_ptr <= '0;
      owner <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wdog <= '0;
`endif
    end else begin
      m_start_tx <= 1'b0;
      grant_done <= '0;
      grant_err <= '0;
      case (state)
        IDLE: if (|req) state <= ARB;
        ARB:
          if (|req) begin
            grant <= sel_gnt;
            owner <= sel_idx;
            m_data_in <= req_byte[{sel_idx, 3'b000} +: BYTE_W];
            retry_cnt <= '0;
            m_start_tx <= 1'b1;
            state <= LAUNCH;
          end else state <= IDLE;
        LAUNCH: begin
`ifdef I2C_ARB_TIMEOUT_EN
          wdog <= '0;
`endif
          state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
`ifdef I2C_ARB_TIMEOUT_EN
          wdog <= wdog + 1'b1;
          if (!m_done && wdog == WDOG_MAX) begin
            grant_err <= grant;
            state <= FAIL;
          end else
`endif
          if (m_done) begin
            if (!m_nack) begin
              grant_done <= grant;
              state <= COMPLETE;
            end else if (retry_cnt < 3'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 3'd1;
              gap_cnt <= '0;
              state <= GAP;
            end else begin
              grant_err <= grant;
              state <= FAIL;
            end
          end else if (m_busy && state == WAIT_BUSY) state <= WAIT_DONE;
        end
        GAP:
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            m_start_tx <= 1'b1;
            state <= LAUNCH;
          end else gap_cnt <= gap_cnt + 8'd1;
        COMPLETE, FAIL: begin
          rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: table-driven and scoreboard checks of the default (no watchdog) arbiter build
module tb_i2c_txn_arbiter;
  localparam int N = 4, GAP = 4, MAXR = 3;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0] grant, grant_done, grant_err;
  logic m_start_tx, arb_busy;
  logic [7:0] m_data_in;
  logic m_busy = 0, m_done = 0, m_nack = 0;
  int errors = 0, checks = 0;
  typedef struct {int client; logic [7:0] b;} exp_t;
  typedef struct {int client; logic [7:0] b; int nacks; bit exp_err;} vec_t;
  exp_t sb[$];
  vec_t vt[4];

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.NUM_REQ(N), .MAX_RETRY(MAXR), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_byte(req_byte), .grant(grant),
    .grant_done(grant_done), .grant_err(grant_err), .m_start_tx(m_start_tx),
    .m_data_in(m_data_in), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
    .arb_busy(arb_busy));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int c, logic [7:0] b, int n);
    repeat (n) sb.push_back('{c, b});
  endtask

  task automatic wait_start(output int waited, output bit ok);
    exp_t e;
    waited = 0;
    while (!m_start_tx && waited < 200) begin
      tick();
      waited++;
    end
    ok = m_start_tx;
    chk("start_seen", ok, 1);
    if (!ok) return;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("grant_owner", grant, 32'(1) << e.client);
    chk("m_data_in", m_data_in, e.b);
  endtask

  task automatic serve(input bit nack, input logic [N-1:0] drop, output int waited);
    bit ok;
    wait_start(waited, ok);
    if (!ok) return;
    req &= ~drop;
    tick();
    chk("start_pulse_width", m_start_tx, 0);
    m_busy = 1;
    repeat (3) tick();
    m_busy = 0;
    m_done = 1;
    m_nack = nack;
    tick();
    m_done = 0;
    m_nack = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, c, launches;
    bit ok;
    vt[0] = '{1, 8'hA4, 0, 0};
    vt[1] = '{2, 8'h5C, 2, 0};
    vt[2] = '{0, 8'h3E, 4, 1};
    vt[3] = '{3, 8'hC7, 1, 0};
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_done", grant_done, 0);
    chk("rst_err", grant_err, 0);
    chk("rst_start", m_start_tx, 0);
    chk("rst_data", m_data_in, 0);
    chk("rst_busy", arb_busy, 0);
    rst = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      c = vt[i].client;
      req_byte[c*8 +: 8] = vt[i].b;
      req[c] = 1'b1;
      launches = (vt[i].nacks > MAXR) ? MAXR + 1 : vt[i].nacks + 1;
      push(c, vt[i].b, launches);
      for (int l = 0; l < launches; l++) begin
        serve(l < vt[i].nacks, '0, w);
        if (l == 0) chk("req_to_start_cycles", w + 1, 3);
        else chk("retry_gap", w, GAP);
      end
      chk("vec_done", grant_done, vt[i].exp_err ? 0 : 32'(1) << c);
      chk("vec_err", grant_err, vt[i].exp_err ? 32'(1) << c : 0);
      req[c] = 1'b0;
      tick();
      chk("vec_pulse_one_cycle", {grant_done, grant_err}, 0);
      chk("vec_idle", arb_busy, 0);
    end
    req_byte = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    for (int k = 0; k < 5; k++) push(k % 4, 8'h11 * 8'((k % 4) + 1), 1);
    for (int k = 0; k < 5; k++) begin
      serve(0, (k == 4) ? 4'hF : 4'h0, w);
      if (k > 0) chk("done_to_next_start", w, 3);
      chk("rr_done", grant_done, 32'(1) << (k % 4));
    end
    tick();
    chk("rr_idle", arb_busy, 0);
    req_byte[15:8] = 8'h9A;
    req_byte[23:16] = 8'h6B;
    req = 4'b0110;
    push(1, 8'h9A, 4);
    push(2, 8'h6B, 1);
    for (int l = 0; l < 4; l++) begin
      serve(1, '0, w);
      req_byte[15:8] = 8'($urandom);
    end
    chk("exhaust_err", grant_err, 4'b0010);
    chk("exhaust_no_done", grant_done, 0);
    req[1] = 1'b0;
    serve(0, 4'b0100, w);
    chk("after_fail_next_start", w, 3);
    chk("dropped_req_done", grant_done, 4'b0100);
    tick();
    chk("exhaust_idle", arb_busy, 0);
    m_done = 1;
    tick();
    m_done = 0;
    chk("idle_mdone_busy", arb_busy, 0);
    chk("idle_mdone_pulses", {grant_done, grant_err}, 0);
    tick();
    chk("idle_mdone_stay", {arb_busy, grant_done, grant_err}, 0);
    req_byte[7:0] = 8'hD2;
    req = 4'b0001;
    push(0, 8'hD2, 1);
    wait_start(w, ok);
    tick();
    m_busy = 1;
    tick();
    m_busy = 0;
    m_done = 1;
    rst = 1;
    tick();
    m_done = 0;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_pulses", {grant_done, grant_err}, 0);
    chk("mid_rst_start", m_start_tx, 0);
    chk("mid_rst_data", m_data_in, 0);
    chk("mid_rst_busy", arb_busy, 0);
    rst = 0;
    req_byte[31:24] = 8'hE1;
    req = 4'b1001;
    push(0, 8'hD2, 1);
    serve(0, 4'b1001, w);
    chk("post_rst_ptr_done", grant_done, 4'b0001);
    tick();
    chk("post_rst_idle", arb_busy, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Shares the single I2C byte-transmit master engine between NUM_REQ client requesters. Each client posts an 8-bit address/data byte. The block selects clients round-robin, launches the master through its start_tx/busy/done handshake, and retries on NACK up to MAX_RETRY times. It returns a per-client completion or error pulse. It sits between the client blocks and the I2C master FSM, and is the only driver of the master's start_tx and data_in.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
MAX_RETRY, 3, extra attempts after a NACK before reporting an error (0..7)
GAP_CYCLES, 4, idle cycles inserted between a NACK and its retry (1..255)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-client request level; held until that client's grant_done pulse
req_byte  in  8*NUM_REQ  client i byte at [8i+7:8i]; stable while req[i] is high
grant  out  NUM_REQ  one-hot; client currently owning the master
grant_done  out  NUM_REQ  one-cycle pulse: owner's transfer ACKed and completed
grant_err  out  NUM_REQ  one-cycle pulse: owner's transfer failed after all retries
m_start_tx  out  1  start request to the master; a single-cycle pulse
m_data_in  out  8  byte to the master; registered copy of the owner's req_byte
m_busy  in  1  master busy
m_done  in  1  master done pulse (one cycle)
m_nack  in  1  sampled with m_done; 1 = slave NACKed
arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; grant=0; grant_done=0; grant_err=0; m_start_tx=0; m_data_in=0; arb_busy=0; retry_cnt=0; rr_ptr=0. Reset mid-transfer abandons the transfer. No pulse is emitted, even if m_done arrives in the same cycle.
- States (3-bit encoding):
  - IDLE: if any req is high, go to ARB.
  - ARB: pick the first requester at or after rr_ptr, modulo NUM_REQ. Set grant one-hot and latch m_data_in from that client's req_byte. Clear retry_cnt. Go to LAUNCH.
  - LAUNCH: m_start_tx=1 for exactly this one cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for m_busy=1, then go to WAIT_DONE. If m_done=1 arrives first, handle it exactly as in WAIT_DONE.
  - WAIT_DONE: on m_done with m_nack=0, go to COMPLETE. On m_done with m_nack=1:
    - if retry_cnt<MAX_RETRY: retry_cnt+1, go to GAP;
    - otherwise go to FAIL.
  - GAP: count GAP_CYCLES cycles, then go to LAUNCH. m_data_in is not re-sampled.
  - COMPLETE: grant_done[owner]=1 for one cycle. Set rr_ptr=owner+1, wrapping NUM_REQ-1 to 0. grant=0. Go to IDLE.
  - FAIL: grant_err[owner]=1 for one cycle. rr_ptr is updated as in COMPLETE. grant=0. Go to IDLE.
- Latency and fairness:
  - Best case from req to m_start_tx: 3 cycles (IDLE, ARB, LAUNCH).
  - Minimum of 2 cycles from grant_done to the next grant.
  - A client is never granted twice while another client's req is continuously high.
- Boundary conditions:
  - Simultaneous requests: the lowest index at or after rr_ptr wins.
  - A client may drop req while granted. The transfer still runs to completion and the pulse is still emitted; the client ignores it.
  - req_byte changes while granted have no effect.
  - MAX_RETRY=0: the first NACK goes directly to FAIL.
  - m_done outside WAIT_BUSY/WAIT_DONE is ignored.

Optional Feature:
I2C_ARB_TIMEOUT_EN
- Defined: adds a 16-bit watchdog, cleared on entry to LAUNCH. If the watchdog reaches 0xFFFF in WAIT_BUSY or WAIT_DONE, the FSM goes to FAIL and pulses grant_err. No retry is attempted on a timeout.
- Not defined: no watchdog logic is present. WAIT_DONE waits indefinitely for m_done.

Decomposition:
- Package i2c_arb_pkg holds:
  - state encoding constants (IDLE, ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP, COMPLETE, FAIL);
  - byte width 8;
  - watchdog width 16 and terminal value 0xFFFF.
- Sub-module rr_select: purely combinational. Inputs are the req vector and rr_ptr; outputs are a one-hot grant and the winner index. Instantiated once.

Test Plan:
- Single request: req=4'b0010, byte 0xA4; master ACKs after 20 cycles. Expect m_start_tx 3 cycles after req, m_data_in=0xA4, grant_done[1] for one cycle, then arb_busy=0.
- Round-robin: req=4'b1111 held, all transfers ACK. Expect grant order 0,1,2,3,0, with exactly one m_start_tx per grant.
- NACK retry: m_nack=1 on the first two attempts, 0 on the third. Expect 3 m_start_tx pulses, each pair spaced at least GAP_CYCLES=4 apart; then grant_done, no grant_err.
- Retry exhaustion: m_nack=1 always, MAX_RETRY=3. Expect exactly 4 launches, then grant_err[owner] for one cycle, then the next requester is granted.
- Reset mid-transfer: assert rst in WAIT_DONE while m_done=1. Expect all outputs at reset values next cycle, no done/err pulse, and rr_ptr=0.
- With I2C_ARB_TIMEOUT_EN: master never asserts m_done. Expect grant_err 65535 cycles after LAUNCH and a return to IDLE.
